// File: rtl/fetchq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetchq_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fq_state_t;

endpackage

// File: rtl/fetchq_fifo.sv
// Ring buffer of fetched entries with read/write pointers and an occupancy count.
module fetchq_fifo
  import fetchq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  fq_entry_t     wrData,
  output fq_entry_t     rdData,
  output logic [CW-1:0] count
);

  fq_entry_t     mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wrData;
  end

  assign rdData = mem[rdPtr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited request issue, in-order response capture, redirect drain.
// Optional same-cycle response bypass when the queue is empty: define FETCHQ_BYPASS_EN.
module fetch_queue
  import fetchq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall_d,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic [63:0] out_pc_plus4,
  output fq_state_t   stateDbg
);

  localparam int CW = $clog2(DEPTH) + 1;

  fq_state_t     state, stateNext;
  logic [CW-1:0] outstanding, discardCnt, count, inFlight, newDiscard;
  logic [63:0]   fetchPc, rspPc;
  logic          accept, rspHit, rspLive, push, pop, bypass;
  fq_entry_t     head, rspEntry, outEntry;

  // Memory handshake: a request transfers when imem_req && imem_ready; a response is
  // a single-cycle imem_rsp_valid pulse, returned in request order.
  assign imem_req  = (state == RUN) && ((count + outstanding) < CW'(DEPTH));
  assign imem_addr = fetchPc;
  assign accept    = imem_req && imem_ready;

  // While draining, discardCnt holds the in-flight count; outstanding is then zero.
  assign inFlight   = (state == DRAIN) ? discardCnt : outstanding;
  assign rspHit     = imem_rsp_valid && (inFlight != '0);
  assign rspLive    = rspHit && (state == RUN);
  assign newDiscard = inFlight + CW'(accept) - CW'(rspHit);

  // Responses return in order, so the oldest request's PC trails fetchPc by outstanding words.
  assign rspPc          = fetchPc - (64'(outstanding) * 64'(INSTR_BYTES));
  assign rspEntry.pc    = rspPc;
  assign rspEntry.instr = imem_rsp_data;

`ifdef FETCHQ_BYPASS_EN
  assign bypass = rspLive && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign pop  = (count != '0) && !stall_d && !redirect_valid;
  assign push = rspLive && !redirect_valid && !(bypass && !stall_d);

  fetchq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clear  (redirect_valid),
    .push   (push),
    .pop    (pop),
    .wrData (rspEntry),
    .rdData (head),
    .count  (count)
  );

  always_comb begin
    outEntry = '0;
    if (count != '0) outEntry = head;
    else if (bypass) outEntry = rspEntry;
  end

  assign out_valid    = (count != '0) || bypass;
  assign out_instr    = outEntry.instr;
  assign out_pc       = outEntry.pc;
  assign out_pc_plus4 = out_valid ? outEntry.pc + 64'(INSTR_BYTES) : 64'h0;
  assign stateDbg     = state;

  always_comb begin
    stateNext = state;
    unique case (state)
      BOOT:    stateNext = RUN;
      RUN:     stateNext = RUN;
      DRAIN:   if (rspHit && discardCnt == CW'(1)) stateNext = RUN;
      default: stateNext = BOOT;
    endcase
    if (redirect_valid) stateNext = (newDiscard != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      outstanding <= '0;
      discardCnt  <= '0;
      fetchPc     <= RESET_PC;
    end else begin
      state <= stateNext;
      if (redirect_valid) begin
        outstanding <= '0;
        discardCnt  <= newDiscard;
        fetchPc     <= redirect_pc;
      end else begin
        if (accept) fetchPc <= fetchPc + 64'(INSTR_BYTES);
        if (state == RUN) outstanding <= outstanding + CW'(accept) - CW'(rspHit);
        if (state == DRAIN && rspHit) discardCnt <= discardCnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a request/entry-list reference model.
module tb_fetch_queue;
  import fetchq_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall_d;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [63:0] out_pc_plus4;
  fq_state_t   stateDbg;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_d        (stall_d),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .stateDbg       (stateDbg)
  );

  int vecCount = 0;
  int errCount = 0;

  // Reference model: queued entries {pc,instr}, requests in flight {stale,addr}.
  logic [95:0] exp_q[$];
  logic [64:0] inflight[$];
  logic [63:0] memAddrQ[$];
  int          memDueQ[$];
  logic [63:0] mPc = 64'h0;
  bit          mBoot = 1'b0;
  int          cycle = 0;
  int          lat = 1;
  int          latMax = 1;
  int          readyPct = 100;
  int          stallPct = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [31:0] instrFor(input logic [63:0] addr);
    logic [29:0] w;
    w = addr[31:2] ^ 30'h2;
    return 32'h00500093 ^ {w, 2'b00};
  endfunction

  task automatic modelStep();
    bit          draining, expReq, expAcc, rspLive, expValid, byp, popOut;
    int          live;
    logic [95:0] expOut;
    logic [63:0] headPc;

    // Memory side follows what the DUT actually did.
    if (imem_rsp_valid) begin
      void'(memAddrQ.pop_front());
      void'(memDueQ.pop_front());
    end
    if (imem_req === 1'b1 && imem_ready) begin
      memAddrQ.push_back(imem_addr);
      memDueQ.push_back(cycle + (latMax > lat ? $urandom_range(latMax, lat) : lat));
    end

    if (rst) begin
      exp_q.delete();
      inflight.delete();
      mPc   = 64'h0;
      mBoot = 1'b1;
      return;
    end

    draining = 1'b0;
    live     = 0;
    foreach (inflight[i]) begin
      if (inflight[i][64]) draining = 1'b1;
      else live++;
    end
    expReq = !mBoot && !draining && (exp_q.size() + live < DEPTH);
    expAcc = expReq && imem_ready;
    checkVal("imem_req", 64'(imem_req), 64'(expReq));
    if (expReq) checkVal("imem_addr", imem_addr, mPc);
    if (mBoot) checkVal("boot_state", 64'(stateDbg), 64'(BOOT));

    rspLive = imem_rsp_valid && inflight.size() != 0 && !inflight[0][64];
    headPc  = (inflight.size() != 0) ? inflight[0][63:0] : 64'h0;

    expValid = exp_q.size() != 0;
    expOut   = expValid ? exp_q[0] : 96'h0;
    byp      = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    if (!expValid && rspLive) begin
      byp      = 1'b1;
      expValid = 1'b1;
      expOut   = {headPc, imem_rsp_data};
    end
`endif
    checkVal("out_valid", 64'(out_valid), 64'(expValid));
    checkVal("out_pc", out_pc, expOut[95:32]);
    checkVal("out_instr", 64'(out_instr), 64'(expOut[31:0]));
    checkVal("out_pc_plus4", out_pc_plus4, expValid ? expOut[95:32] + 64'd4 : 64'h0);

    popOut = expValid && !stall_d;
    if (imem_rsp_valid && inflight.size() != 0) void'(inflight.pop_front());
    if (redirect_valid) begin
      if (expAcc) inflight.push_back({1'b0, mPc});
      foreach (inflight[i]) inflight[i][64] = 1'b1;
      exp_q.delete();
      mPc = redirect_pc;
    end else begin
      if (popOut && !byp) void'(exp_q.pop_front());
      if (rspLive && !(byp && popOut)) exp_q.push_back({headPc, imem_rsp_data});
      if (expAcc) begin
        inflight.push_back({1'b0, mPc});
        mPc = mPc + 64'd4;
      end
    end
    mBoot = 1'b0;
  endtask

  task automatic runCycle(input bit rstIn, input bit redirIn, input logic [63:0] tgt);
    @(posedge clk);
    #1;
    rst            = rstIn;
    imem_ready     = ($urandom_range(99) < readyPct);
    stall_d        = ($urandom_range(99) < stallPct);
    redirect_valid = redirIn;
    redirect_pc    = tgt;
    imem_rsp_valid = (memDueQ.size() != 0) && (memDueQ[0] <= cycle);
    imem_rsp_data  = imem_rsp_valid ? instrFor(memAddrQ[0]) : $urandom;
    @(negedge clk);
    modelStep();
    cycle++;
  endtask

  task automatic runN(input int n);
    for (int i = 0; i < n; i++) runCycle(1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    rst            = 1'b1;
    imem_ready     = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    stall_d        = 1'b0;

    runCycle(1'b1, 1'b0, 64'h0);
    runCycle(1'b1, 1'b0, 64'h0);

    // Streaming: latency 1, always ready, no stall.
    lat = 1; latMax = 1; readyPct = 100; stallPct = 0;
    runN(20);

    // Long decode stall fills credits, then release.
    stallPct = 100;
    runN(10);
    stallPct = 0;
    runN(10);

    // Latency 3 with a redirect while requests are in flight.
    lat = 3; latMax = 3;
    runN(6);
    runCycle(1'b0, 1'b1, 64'h100);
    runN(15);

    // Randomized traffic with occasional redirects.
    lat = 1; latMax = 4; readyPct = 70; stallPct = 30;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) < 5)
        runCycle(1'b0, 1'b1, {32'h0, $urandom_range(32'hffff, 0) * 32'd4});
      else
        runCycle(1'b0, 1'b0, 64'h0);
    end

    // Mid-operation reset with entries stored and requests in flight.
    lat = 3; latMax = 3; readyPct = 100; stallPct = 100;
    runN(5);
    runCycle(1'b1, 1'b0, 64'h0);
    readyPct = 0;
    runN(6);
    readyPct = 80; stallPct = 20; lat = 1; latMax = 3;
    runN(60);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
